// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state encoding
// and default datapath widths.
package alu_arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int SREG_W_DEF = 4;
    localparam int OP_W_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way grant generator for the ALU arbiter.
// Returns a one-hot grant (or zero when nobody is requesting).
// Build option ALU_ARB_FIXED_PRIO_EN: requester 0 always beats requester 1
// and the pointer input is ignored. Otherwise the pointer decides ties.
module alu_rr_arbiter (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ptr_i;

    // req0 wins whenever it is present
    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = valid_i[0];
        gnt_o[1] = valid_i[1] & ~valid_i[0];
    end
`else
    // A lone requester wins outright; on a tie the pointer names the winner
    always_comb begin
        gnt_o = valid_i;
        if (valid_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one transaction at a
// time. Operands are registered into the ALU inputs on accept, the ALU
// settles for one cycle, and its outputs are captured into the response
// registers of the granted requester.
// Build option ALU_ARB_FIXED_PRIO_EN: fixed priority (req0 first), no
// round-robin pointer.
//
// state | meaning
// IDLE  | waiting for a request; grant decided combinationally
// EXEC  | ALU inputs held, ALU settling
// RESP  | response valid to the granted requester until it is consumed
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SREG_W = SREG_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic [DATA_W-1:0] rsp0_high,
    output logic [SREG_W-1:0] rsp0_sreg,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [DATA_W-1:0] rsp1_high,
    output logic [SREG_W-1:0] rsp1_sreg,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_fsel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] alu_high,
    input  logic [SREG_W-1:0] alu_sreg,

    output logic              busy
);

    arb_state_t        state_q;
    logic              gnt_id_q;
    logic              ptr_q;
    logic              busy_q;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [OP_W-1:0]   alu_fsel_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] high_q;
    logic [SREG_W-1:0] sreg_q;

    logic [1:0]        gnt;
    logic              in_idle;
    logic              accept;
    logic              rsp_take;
    logic [DATA_W-1:0] alu_a_d;
    logic [DATA_W-1:0] alu_b_d;
    logic [OP_W-1:0]   alu_fsel_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign ptr_q = 1'b0;
`endif

    alu_rr_arbiter u_rr_arbiter (
        .valid_i ({req1_valid, req0_valid}),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt)
    );

    // Ready only in IDLE, only for the granted requester, never during reset
    assign in_idle    = (state_q == ST_IDLE) && !reset;
    assign req0_ready = in_idle && gnt[0];
    assign req1_ready = in_idle && gnt[1];
    assign accept     = req0_ready || req1_ready;

    assign alu_a_d    = gnt[1] ? req1_a  : req0_a;
    assign alu_b_d    = gnt[1] ? req1_b  : req0_b;
    assign alu_fsel_d = gnt[1] ? req1_op : req0_op;

    // A ready on the non-granted response port is ignored
    assign rsp_take = (state_q == ST_RESP) &&
                      (gnt_id_q ? rsp1_ready : rsp0_ready);

    // Transaction FSM with registered ALU inputs, payload and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gnt_id_q     <= 1'b0;
            busy_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_fsel_q   <= '0;
            result_q     <= '0;
            high_q       <= '0;
            sreg_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a_q    <= alu_a_d;
                        alu_b_q    <= alu_b_d;
                        alu_fsel_q <= alu_fsel_d;
                        gnt_id_q   <= gnt[1];
                        busy_q     <= 1'b1;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q     <= alu_out;
                    high_q       <= alu_high;
                    sreg_q       <= alu_sreg;
                    rsp0_valid_q <= ~gnt_id_q;
                    rsp1_valid_q <= gnt_id_q;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_take) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // After serving G the other requester becomes preferred
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (rsp_take) begin
            ptr_q <= ~gnt_id_q;
        end
    end
`endif

    // Only the valid of the granted port is ever high, so one payload
    // register set serves both response ports
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = result_q;
    assign rsp0_high   = high_q;
    assign rsp0_sreg   = sreg_q;
    assign rsp1_result = result_q;
    assign rsp1_high   = high_q;
    assign rsp1_sreg   = sreg_q;

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_fsel = alu_fsel_q;
    assign busy     = busy_q;

endmodule
